// File: rtl/l2_cacheline_adaptor_if.sv
// Bundle between the L2 physical-memory port (line side) and main memory (burst side).
// The adaptor takes the slave view; whatever drives L2 requests and memory beats takes the master view.
interface l2_cacheline_adaptor_if #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
);
    // L2 side
    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic [ADDR_W-1:0]  address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;
    // Memory side
    logic [BURST_W-1:0] burst_i;
    logic [BURST_W-1:0] burst_o;
    logic [ADDR_W-1:0]  address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/l2_cacheline_adaptor.sv
// Converts one 256-bit L2 line transfer into a 4-beat 64-bit memory burst and back,
// answering the L2 with a single resp pulse once the whole burst has completed.
module l2_cacheline_adaptor #(
    parameter int LINE_W    = 256,
    parameter int BURST_W   = 64,
    parameter int NUM_BEATS = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    l2_cacheline_adaptor_if.slave  bus
);

    localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(NUM_BEATS - 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [LINE_W-1:0]   buf_q,   buf_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;

    // NOTE: the line buffer is reset too, so an abandoned burst never leaks partial data onto line_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
        end else begin
            // NOTE: non-blocking here so every flop samples the pre-edge values computed in always_comb.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state: requests are only looked at in IDLE, beats only in READ/WRITE.
    always_comb begin
        // NOTE: hold-by-default assignments keep this block free of inferred latches.
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        addr_d  = addr_q;

        unique case (state_q)
            IDLE: begin
                if (bus.read_i) begin
                    addr_d  = bus.address_i & ADDR_MASK;
                    cnt_d   = '0;
                    state_d = READ;
                end else if (bus.write_i) begin
                    addr_d  = bus.address_i & ADDR_MASK;
                    buf_d   = bus.line_i;
                    cnt_d   = '0;
                    state_d = WRITE;
                end
            end
            READ: begin
                if (bus.resp_i) begin
                    buf_d[cnt_q*BURST_W +: BURST_W] = bus.burst_i;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (bus.resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode only registered state, so they are glitch-free and clear instantly on reset.
    always_comb begin
        bus.resp_o    = (state_q == DONE);
        bus.read_o    = (state_q == READ);
        bus.write_o   = (state_q == WRITE);
        bus.line_o    = buf_q;
        bus.address_o = '0;
        bus.burst_o   = '0;
        if (state_q == READ || state_q == WRITE) begin
            bus.address_o = addr_q;
        end
        if (state_q == WRITE) begin
            bus.burst_o = buf_q[cnt_q*BURST_W +: BURST_W];
        end
    end

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Randomized bench for l2_cacheline_adaptor: a transaction-level model predicts beats,
// addresses, line contents and the resp pulse, with directed cases for reset and corner behaviour.
module tb_l2_cacheline_adaptor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l2_cacheline_adaptor_if #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) bus ();

    l2_cacheline_adaptor #(
        .LINE_W(256), .BURST_W(64), .NUM_BEATS(4), .ADDR_W(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Model state: what line_o must show between transactions.
    logic [255:0] model_line;
    // Stimulus controls: fixed resp_i pattern and fixed beat data for directed cases.
    logic         use_pat;
    logic [15:0]  pat;
    logic         fixed_beats;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.resp_i    = 1'b0;
        bus.burst_i   = '0;
        bus.address_i = '0;
        bus.line_i    = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read_o"},    bus.read_o,    '0);
        check({tag, "_write_o"},   bus.write_o,   '0);
        check({tag, "_resp_o"},    bus.resp_o,    '0);
        check({tag, "_address_o"}, bus.address_o, '0);
        check({tag, "_burst_o"},   bus.burst_o,   '0);
        check({tag, "_line_o"},    bus.line_o,    '0);
    endtask

    // One complete transaction, starting in an IDLE cycle and ending in the IDLE cycle after DONE.
    task automatic run_txn(input bit is_read, input bit both, input logic [31:0] addr,
                           input logic [255:0] line, input bit drop);
        logic [31:0]  exp_addr;
        logic [63:0]  beats[$];
        logic [255:0] exp_line;
        logic [63:0]  beat;
        bit           r;
        int           cyc;
        bit           eff_read;

        eff_read = is_read | both;
        exp_addr = {addr[31:5], 5'b00000};

        check("idle_resp_o",  bus.resp_o,  '0);
        check("idle_read_o",  bus.read_o,  '0);
        check("idle_write_o", bus.write_o, '0);
        check("idle_burst_o", bus.burst_o, '0);
        check("held_line_o",  bus.line_o,  model_line);

        bus.read_i    = eff_read;
        bus.write_i   = !is_read | both;
        bus.address_i = addr;
        bus.line_i    = line;
        bus.resp_i    = 1'b0;
        tick();

        cyc = 0;
        while (beats.size() < 4 && cyc < 64) begin
            check("busy_read_o",  bus.read_o,    eff_read);
            check("busy_write_o", bus.write_o,   !eff_read);
            check("busy_addr_o",  bus.address_o, exp_addr);
            check("early_resp_o", bus.resp_o,    '0);
            if (!eff_read) begin
                check("burst_o", bus.burst_o, line[64*beats.size() +: 64]);
            end
            if (drop) begin
                bus.read_i    = 1'b0;
                bus.write_i   = 1'b0;
                bus.address_i = $urandom;
                bus.line_i    = {8{$urandom}};
            end
            if (use_pat) r = (cyc < 16) ? pat[cyc] : 1'b1;
            else         r = ($urandom_range(0, 2) != 0);
            beat = fixed_beats ? 64'h1111_1111_1111_1111 * 64'(beats.size() + 1)
                               : {$urandom, $urandom};
            bus.resp_i  = r;
            bus.burst_i = beat;
            if (r) beats.push_back(beat);
            tick();
            cyc++;
        end
        check("beats_within_budget", beats.size(), 4);

        check("done_resp_o",  bus.resp_o,  1);
        check("done_read_o",  bus.read_o,  '0);
        check("done_write_o", bus.write_o, '0);
        check("done_burst_o", bus.burst_o, '0);
        if (eff_read) begin
            if (beats.size() == 4) exp_line = {beats[3], beats[2], beats[1], beats[0]};
            else                   exp_line = '0;
            model_line = exp_line;
            check("done_line_o", bus.line_o, exp_line);
        end else begin
            model_line = line;
        end

        // Anything presented during DONE must be ignored.
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        bus.resp_i  = 1'($urandom_range(0, 1));
        bus.burst_i = {$urandom, $urandom};
        tick();
        bus.resp_i  = 1'b0;
    endtask

    initial begin
        logic [255:0] wline;
        idle_inputs();
        use_pat     = 1'b0;
        pat         = '0;
        fixed_beats = 1'b0;
        model_line  = '0;
        rst         = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_all_zero("post_reset");

        // Read without gaps, unaligned address.
        use_pat     = 1'b1;
        pat         = 16'hFFFF;
        fixed_beats = 1'b1;
        run_txn(1'b1, 1'b0, 32'h0000_1234, '0, 1'b0);
        check("dir_read_line", bus.line_o,
              {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Write with gaps 1,0,1,0,0,1,1, started right after the read's DONE.
        pat         = 16'h0065;
        fixed_beats = 1'b0;
        wline = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        run_txn(1'b0, 1'b0, 32'h8000_004F, wline, 1'b0);

        // Simultaneous read and write requests: read wins.
        use_pat = 1'b0;
        run_txn(1'b1, 1'b1, $urandom, {8{$urandom}}, 1'b0);

        // Stray resp_i while IDLE, then a read whose request drops after acceptance.
        bus.resp_i  = 1'b1;
        bus.burst_i = {$urandom, $urandom};
        tick();
        bus.resp_i  = 1'b0;
        check("stray_read_o",  bus.read_o,  '0);
        check("stray_write_o", bus.write_o, '0);
        check("stray_resp_o",  bus.resp_o,  '0);
        check("stray_line_o",  bus.line_o,  model_line);
        run_txn(1'b1, 1'b0, $urandom, '0, 1'b1);

        // Randomized back-to-back traffic.
        for (int i = 0; i < 24; i++) begin
            run_txn(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    $urandom, {8{$urandom}}, ($urandom_range(0, 2) == 0));
        end

        // Reset after beat 2 of a read.
        bus.read_i    = 1'b1;
        bus.address_i = 32'h0000_ABCD;
        tick();
        bus.read_i  = 1'b0;
        bus.resp_i  = 1'b1;
        bus.burst_i = {$urandom, $urandom};
        tick();
        bus.burst_i = {$urandom, $urandom};
        tick();
        bus.resp_i  = 1'b0;
        check("pre_rst_read_o", bus.read_o, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        model_line = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("after_rst_resp_o", bus.resp_o, '0);
            check("after_rst_read_o", bus.read_o, '0);
        end
        run_txn(1'b0, 1'b0, $urandom, {8{$urandom}}, 1'b0);
        run_txn(1'b1, 1'b0, $urandom, '0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l2_cacheline_adaptor.md
Name: l2_cacheline_adaptor

Overview:
Downstream neighbour of the L2 cache. It sits between the L2 cache's physical-memory port (256-bit line, pmem_* handshake) and main memory, which transfers 64-bit beats in 4-beat bursts. On a read it gathers 4 beats into one 256-bit line; on a write it splits one line into 4 beats. It answers the L2 with a single-cycle resp only after the whole burst completes.

Parameters:
- LINE_W, 256, line width on the L2 side.
- BURST_W, 64, beat width on the memory side.
- NUM_BEATS, 4, beats per line; must equal LINE_W/BURST_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- line_i  input  256  write line from L2 (pmem_wdata).
- line_o  output  256  read line to L2 (pmem_rdata).
- address_i  input  32  line address from L2 (pmem_address).
- read_i  input  1  line read request (pmem_read).
- write_i  input  1  line write request (pmem_write).
- resp_o  output  1  transaction-complete pulse (pmem_resp).
- burst_i  input  64  read beat from memory.
- burst_o  output  64  write beat to memory.
- address_o  output  32  burst address to memory.
- read_o  output  1  burst read request.
- write_o  output  1  burst write request.
- resp_i  input  1  memory beat strobe; one beat per cycle it is high.

Behaviour:
- Reset, asynchronous and taking effect immediately: state=IDLE, beat counter=0, line buffer=0, address register=0. read_o, write_o, resp_o, address_o, line_o and burst_o are all 0.
- Reset mid-transaction abandons the burst. The stale half-filled buffer is cleared, and no resp_o is issued.
- States are IDLE, READ, WRITE and DONE.
- IDLE, read_i=1: latch the address with bits [4:0] forced to 0, clear the counter, go to READ.
- IDLE, write_i=1 and read_i=0: latch the address with [4:0]=0, latch line_i into the buffer, clear the counter, go to WRITE.
- IDLE, read_i and write_i both 1: read wins.
- READ: read_o=1 and address_o=latched address (both registered, stable for the whole burst).
  - Each cycle with resp_i=1: buffer[64*cnt +: 64] <= burst_i, then cnt++.
  - On the beat with cnt==3: go to DONE; read_o drops in DONE.
- WRITE: write_o=1, address_o=latched address, burst_o=buffer[64*cnt +: 64] (combinational from cnt).
  - Each cycle with resp_i=1: cnt++.
  - On the beat with cnt==3: go to DONE.
- Memory may insert gap cycles (resp_i=0) between beats. The counter holds and the outputs stay stable during gaps.
- DONE: resp_o=1 for exactly one cycle, then go to IDLE unconditionally.
  - Requests seen in DONE are ignored; the L2 deasserts read_i/write_i after sampling resp_o.
  - resp_i seen in DONE is ignored.
- line_o = buffer contents. The value is valid in DONE after a read and is held until the next transaction starts loading the buffer.
- resp_i seen in IDLE is ignored.
- read_i or write_i dropping, or address_i/line_i changing, after acceptance has no effect; the burst always completes.
- burst_o is 0 outside WRITE.
- Latency: request high in cycle 0 gives read_o/write_o high in cycle 1. With back-to-back beats in cycles 1–4, resp_o=1 in cycle 5. Each gap cycle adds one cycle.
- Back-to-back transactions: a new request may be accepted in the IDLE cycle right after DONE.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately, without waiting for a clock edge; after release, state is IDLE.
- Read, no gaps: read_i=1, address_i=0x0000_1234 -> address_o=0x0000_1220 and read_o=1 at cycle 1. Beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 in cycles 1–4 -> resp_o=1 only at cycle 5, line_o={0x44..44,0x33..33,0x22..22,0x11..11}, read_o=0 at cycle 5.
- Write with gaps: line_i=0xDDDD..CCCC..BBBB..AAAA, resp_i pattern 1,0,1,0,0,1,1 -> burst_o shows 0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD.. in order and holds during gaps; resp_o pulses one cycle after the 4th beat; write_o stays high throughout.
- Simultaneous read_i=1 and write_i=1 in IDLE -> read burst starts (read_o=1, write_o=0).
- Request dropped mid-burst and stray resp_i: read_i falls after cycle 1, plus a resp_i pulse while in IDLE -> the burst still completes with 4 beats and resp_o=1; the IDLE-time resp_i causes no state change.
- Back-to-back and reset mid-op: a write immediately after a read's DONE is accepted the next cycle. Separately, rst asserted after beat 2 of a read -> no resp_o is issued and read_o=0 immediately.
